// File: rtl/port_lookup_sched_pkg.sv
// Shared constants, types and FSM encoding for the port lookup scheduler.
package port_lookup_sched_pkg;
  localparam int         ENG_LAT     = 3;
  localparam logic [9:0] MISS_IDX    = 10'd530;
  localparam logic [1:0] RAM_SEL_H1  = 2'd0;
  localparam logic [1:0] RAM_SEL_H2  = 2'd1;
  localparam logic [1:0] RAM_SEL_PAT = 2'd2;

  typedef logic [15:0] port_t;
  typedef logic [9:0]  idx_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_WRITE
  } state_e;
endpackage

// File: rtl/port_lookup_sched_if.sv
// Requester, engine and table-write signals of the port lookup scheduler.
interface port_lookup_sched_if
  import port_lookup_sched_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_port;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic                rsp_hit;
  idx_t                rsp_index;
  port_t               eng_pattern;
  idx_t                eng_index;
  logic                cfg_wr_valid;
  logic [1:0]          cfg_ram_sel;
  idx_t                cfg_addr;
  port_t               cfg_data;
  logic                cfg_wr_ready;
  logic [2:0]          tbl_we;
  idx_t                tbl_addr;
  port_t               tbl_din;

  modport slave (
    input  req_valid, req_port, eng_index, cfg_wr_valid, cfg_ram_sel, cfg_addr, cfg_data,
    output req_ready, rsp_valid, rsp_hit, rsp_index, eng_pattern, cfg_wr_ready,
           tbl_we, tbl_addr, tbl_din
  );

  modport master (
    output req_valid, req_port, eng_index, cfg_wr_valid, cfg_ram_sel, cfg_addr, cfg_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_index, eng_pattern, cfg_wr_ready,
           tbl_we, tbl_addr, tbl_din
  );
endinterface

// File: rtl/port_lookup_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the most recent grant.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] nextPtr_q, nextPtr_d;
  logic [PW:0]   cand;
  logic [PW-1:0] candId;

  // Descending scan so the candidate closest to nextPtr_q wins.
  always_comb begin
    grant_o   = '0;
    nextPtr_d = nextPtr_q;
    cand      = '0;
    candId    = '0;
    if (en_i) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = {1'b0, nextPtr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
        candId = cand[PW-1:0];
        if (req_i[candId]) begin
          grant_o         = '0;
          grant_o[candId] = 1'b1;
          if (int'(candId) == N_REQ - 1) nextPtr_d = '0;
          else nextPtr_d = candId + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) nextPtr_q <= '0;
    else     nextPtr_q <= nextPtr_d;
  end
endmodule

// File: rtl/port_lookup_sched.sv
// Shares the fixed-latency port lookup engine between requesters and
// serialises table writes behind a full engine drain.
module port_lookup_sched #(
  parameter int         N_REQ    = 2,
  parameter int         LAT      = port_lookup_sched_pkg::ENG_LAT,
  parameter logic [9:0] MISS_IDX = port_lookup_sched_pkg::MISS_IDX
) (
  input logic                clk,
  input logic                rst,
  port_lookup_sched_if.slave bus
);
  import port_lookup_sched_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  state_e           state_q, state_d;
  logic             prevWrite_q;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [LAT-1:0]   tagValid_q;
  logic [IW-1:0]    tagId_q [LAT];
  logic [N_REQ-1:0] rspValid_q;
  logic             rspHit_q;
  idx_t             rspIndex_q;

  logic [N_REQ-1:0] grant;
  logic             arbEn;
  logic             issue;
  logic             retire;
  logic [IW-1:0]    grantId;
  port_t            grantPort;

  rr_arbiter #(.N_REQ(N_REQ)) uArb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (bus.req_valid),
    .en_i   (arbEn),
    .grant_o(grant)
  );

  always_comb begin
    grantId   = '0;
    grantPort = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grantId   = IW'(i);
        grantPort = bus.req_port[16*i +: 16];
      end
    end
  end

  assign issue           = |grant;
  assign retire          = tagValid_q[LAT-1];
  assign bus.req_ready   = grant;
  assign bus.eng_pattern = grantPort;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_hit     = rspHit_q;
  assign bus.rsp_index   = rspIndex_q;

  always_comb begin
    state_d          = state_q;
    arbEn            = 1'b0;
    bus.cfg_wr_ready = 1'b0;
    bus.tbl_we       = '0;
    bus.tbl_addr     = '0;
    bus.tbl_din      = '0;
    case (state_q)
      ST_RUN: begin
        // The first RUN cycle after a write serves a pending lookup so writes cannot starve lookups.
        if (bus.cfg_wr_valid && !(prevWrite_q && (|bus.req_valid))) state_d = ST_DRAIN;
        else arbEn = 1'b1;
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d          = ST_RUN;
        bus.cfg_wr_ready = 1'b1;
        bus.tbl_addr     = bus.cfg_addr;
        bus.tbl_din      = bus.cfg_data;
        case (bus.cfg_ram_sel)
          RAM_SEL_H1:  bus.tbl_we = 3'b001;
          RAM_SEL_H2:  bus.tbl_we = 3'b010;
          RAM_SEL_PAT: bus.tbl_we = 3'b100;
          default:     bus.tbl_we = 3'b000;
        endcase
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      state_d          = ST_RUN;
      arbEn            = 1'b0;
      bus.cfg_wr_ready = 1'b0;
      bus.tbl_we       = '0;
      bus.tbl_addr     = '0;
      bus.tbl_din      = '0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire)      inflight_d = inflight_q + CW'(1);
    else if (retire && !issue) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      prevWrite_q <= 1'b0;
      inflight_q  <= '0;
      tagValid_q  <= '0;
      rspValid_q  <= '0;
      rspHit_q    <= 1'b0;
      rspIndex_q  <= '0;
    end else begin
      state_q       <= state_d;
      prevWrite_q   <= (state_q == ST_WRITE);
      inflight_q    <= inflight_d;
      tagValid_q[0] <= issue;
      for (int i = 1; i < LAT; i++) tagValid_q[i] <= tagValid_q[i-1];
      rspValid_q <= '0;
      rspHit_q   <= 1'b0;
      rspIndex_q <= '0;
      if (retire) begin
        rspValid_q[tagId_q[LAT-1]] <= 1'b1;
        rspHit_q                   <= (bus.eng_index != MISS_IDX);
        rspIndex_q                 <= bus.eng_index;
      end
    end
  end

  always_ff @(posedge clk) begin
    tagId_q[0] <= grantId;
    for (int i = 1; i < LAT; i++) tagId_q[i] <= tagId_q[i-1];
  end
endmodule

// File: tb/tb_port_lookup_sched.sv
// Self-checking bench for port_lookup_sched with a behavioural lookup engine
// and a response scoreboard keyed on the expected response cycle.
module tb_port_lookup_sched;
  import port_lookup_sched_pkg::*;

  localparam int N = 2;

  typedef struct {
    logic [N-1:0] oneHot;
    logic [9:0]   idx;
    logic         hit;
    int           due;
  } exp_t;

  typedef struct {
    int          id;
    logic [15:0] port;
    logic [9:0]  expIdx;
    logic        expHit;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  port_lookup_sched_if #(.N_REQ(N)) ifc ();

  port_lookup_sched #(.N_REQ(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int   errorCount;
  int   checkCount;
  int   cycle;
  bit   monEn;
  exp_t sbQ[$];
  exp_t monE;
  vec_t vecs[6];

  // Lookup engine model: fixed ports plus pattern-table writes, latency ENG_LAT.
  bit       written [65536];
  bit [9:0] mapped  [65536];
  bit [9:0] idxPipe [ENG_LAT];

  function automatic logic [9:0] modelLookup(input logic [15:0] p);
    if (written[p]) return mapped[p];
    if (p == 16'd80) return 10'd1;
    if (p == 16'd22) return 10'd7;
    return MISS_IDX;
  endfunction

  always @(posedge clk) begin
    cycle      <= cycle + 1;
    idxPipe[0] <= modelLookup(ifc.eng_pattern);
    for (int i = 1; i < ENG_LAT; i++) idxPipe[i] <= idxPipe[i-1];
    if (ifc.tbl_we[2]) begin
      written[ifc.tbl_din] <= 1'b1;
      mapped[ifc.tbl_din]  <= ifc.tbl_addr;
    end
  end

  assign ifc.eng_index = idxPipe[ENG_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int id, input logic [9:0] idx, input logic hit);
    exp_t e;
    e.oneHot     = '0;
    e.oneHot[id] = 1'b1;
    e.idx        = idx;
    e.hit        = hit;
    e.due        = cycle + 4;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [N-1:0] oh;
    oh                          = '0;
    oh[v.id]                    = 1'b1;
    ifc.req_valid               = '0;
    ifc.req_valid[v.id]         = 1'b1;
    ifc.req_port[16*v.id +: 16] = v.port;
    @(negedge clk);
    checkOutput("vec_ready", 32'(ifc.req_ready), 32'(oh));
    if (ifc.req_ready[v.id]) pushExp(v.id, v.expIdx, v.expHit);
    tick();
    ifc.req_valid = '0;
  endtask

  // Response monitor: any strobe, or any expected strobe falling due, is compared.
  always @(negedge clk) begin
    if (monEn && !rst) begin
      if ((sbQ.size() > 0 && sbQ[0].due == cycle) || ifc.rsp_valid != '0) begin
        if (sbQ.size() > 0 && sbQ[0].due == cycle) begin
          monE = sbQ.pop_front();
        end else begin
          monE.oneHot = '0;
          monE.idx    = '0;
          monE.hit    = 1'b0;
          monE.due    = cycle;
        end
        checkOutput("rsp_valid", 32'(ifc.rsp_valid), 32'(monE.oneHot));
        checkOutput("rsp_index", 32'(ifc.rsp_index), 32'(monE.idx));
        checkOutput("rsp_hit", 32'(ifc.rsp_hit), 32'(monE.hit));
      end else begin
        checkOutput("rsp_idle", {21'b0, ifc.rsp_hit, ifc.rsp_index}, 32'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    int  writes;
    int  grantsSince;
    bit  done;
    logic [15:0] seqPorts [3];

    vecs[0] = '{0, 16'd80,    10'd1,   1'b1};
    vecs[1] = '{1, 16'd80,    10'd1,   1'b1};
    vecs[2] = '{0, 16'd12345, 10'd530, 1'b0};
    vecs[3] = '{1, 16'd22,    10'd7,   1'b1};
    vecs[4] = '{0, 16'd443,   10'd530, 1'b0};
    vecs[5] = '{1, 16'd12345, 10'd530, 1'b0};
    seqPorts[0] = 16'd80;
    seqPorts[1] = 16'd22;
    seqPorts[2] = 16'd80;

    rst              = 1'b1;
    ifc.req_valid    = '0;
    ifc.req_port     = '0;
    ifc.cfg_wr_valid = 1'b0;
    ifc.cfg_ram_sel  = '0;
    ifc.cfg_addr     = '0;
    ifc.cfg_data     = '0;
    tick();
    @(negedge clk);
    checkOutput("reset_rsp", {19'b0, ifc.rsp_valid, ifc.rsp_hit, ifc.rsp_index}, 32'd0);
    checkOutput("reset_ctl", {26'b0, ifc.req_ready, ifc.cfg_wr_ready, ifc.tbl_we}, 32'd0);
    tick();
    rst   = 1'b0;
    monEn = 1'b1;

    $display("[TB] single lookups from the vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      repeat (5) tick();
    end

    $display("[TB] both requesters valid for 8 cycles");
    ifc.req_port[15:0]  = 16'd80;
    ifc.req_port[31:16] = 16'd22;
    ifc.req_valid       = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("alt_grant", 32'(ifc.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (ifc.req_ready == 2'b01) pushExp(0, 10'd1, 1'b1);
      else if (ifc.req_ready == 2'b10) pushExp(1, 10'd7, 1'b1);
      tick();
    end
    ifc.req_valid = '0;
    repeat (6) tick();

    $display("[TB] pattern write behind three in-flight lookups");
    ifc.req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      ifc.req_port[15:0] = seqPorts[k];
      @(negedge clk);
      checkOutput("b2b_grant", 32'(ifc.req_ready), 32'd1);
      if (ifc.req_ready[0]) pushExp(0, modelLookup(seqPorts[k]), 1'b1);
      tick();
    end
    ifc.req_port[15:0] = 16'd443;
    ifc.cfg_wr_valid   = 1'b1;
    ifc.cfg_ram_sel    = RAM_SEL_PAT;
    ifc.cfg_addr       = 10'd5;
    ifc.cfg_data       = 16'd443;
    waited             = 0;
    done               = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (ifc.cfg_wr_ready) begin
        done = 1'b1;
        checkOutput("drain_cycles", 32'(waited), 32'd4);
        checkOutput("pat_we", 32'(ifc.tbl_we), 32'b100);
        checkOutput("pat_addr", 32'(ifc.tbl_addr), 32'd5);
        checkOutput("pat_din", 32'(ifc.tbl_din), 32'd443);
        checkOutput("write_ready", 32'(ifc.req_ready), 32'd0);
      end else begin
        checkOutput("drain_block", {27'b0, ifc.req_ready, ifc.tbl_we}, 32'd0);
        waited++;
      end
      tick();
    end
    if (!done) checkOutput("pat_write_timeout", 32'd0, 32'd1);
    ifc.cfg_wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_write_grant", 32'(ifc.req_ready), 32'd1);
    if (ifc.req_ready[0]) pushExp(0, 10'd5, 1'b1);
    tick();
    ifc.req_valid = '0;
    repeat (6) tick();

    $display("[TB] continuous writes with requester 0 held valid");
    ifc.req_port[15:0] = 16'd80;
    ifc.req_valid      = 2'b01;
    ifc.cfg_ram_sel    = RAM_SEL_H2;
    ifc.cfg_addr       = 10'd9;
    ifc.cfg_data       = 16'h1234;
    ifc.cfg_wr_valid   = 1'b1;
    writes             = 0;
    grantsSince        = 0;
    for (int k = 0; k < 80 && writes < 4; k++) begin
      @(negedge clk);
      if (ifc.req_ready[0]) begin
        grantsSince++;
        pushExp(0, 10'd1, 1'b1);
      end
      if (ifc.cfg_wr_ready) begin
        checkOutput("h2_we", 32'(ifc.tbl_we), 32'b010);
        if (writes > 0) checkOutput("grant_between_writes", 32'(grantsSince), 32'd1);
        writes++;
        grantsSince = 0;
      end
      tick();
    end
    checkOutput("write_count", 32'(writes), 32'd4);
    ifc.cfg_wr_valid = 1'b0;
    ifc.req_valid    = '0;
    repeat (6) tick();

    $display("[TB] reserved table select drops the write");
    ifc.cfg_ram_sel  = 2'd3;
    ifc.cfg_addr     = 10'd1;
    ifc.cfg_wr_valid = 1'b1;
    done             = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (ifc.cfg_wr_ready) begin
        done = 1'b1;
        checkOutput("dropped_we", 32'(ifc.tbl_we), 32'd0);
      end
      tick();
    end
    if (!done) checkOutput("sel3_write_timeout", 32'd0, 32'd1);
    ifc.cfg_wr_valid = 1'b0;
    repeat (3) tick();

    $display("[TB] reset with two lookups in flight");
    ifc.req_port[15:0]  = 16'd80;
    ifc.req_port[31:16] = 16'd22;
    ifc.req_valid       = 2'b01;
    @(negedge clk);
    checkOutput("pre_rst_grant0", 32'(ifc.req_ready), 32'd1);
    tick();
    ifc.req_valid = 2'b10;
    @(negedge clk);
    checkOutput("pre_rst_grant1", 32'(ifc.req_ready), 32'd2);
    tick();
    ifc.req_valid = 2'b11;
    rst           = 1'b1;
    sbQ.delete();
    tick();
    @(negedge clk);
    checkOutput("rst_rsp", {19'b0, ifc.rsp_valid, ifc.rsp_hit, ifc.rsp_index}, 32'd0);
    checkOutput("rst_ctl", {26'b0, ifc.req_ready, ifc.cfg_wr_ready, ifc.tbl_we}, 32'd0);
    checkOutput("rst_pattern", 32'(ifc.eng_pattern), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_grant_after_rst", 32'(ifc.req_ready), 32'd1);
    if (ifc.req_ready[0]) pushExp(0, 10'd1, 1'b1);
    tick();
    ifc.req_valid = '0;
    repeat (8) tick();

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
